// File: rtl/pipe_data_path_if.sv
// Instruction/result handshake bundle for the two-stage EX->WB datapath.
// The slave side is the datapath; the master side is the decoder/downstream pair.
interface pipe_data_path_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic             wb_en;
    logic             flag_ld;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags_out;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, imm, use_imm, wb_en, flag_ld, out_ready,
        input  in_ready, out_valid, result, flags_out
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, imm, use_imm, wb_en, flag_ld, out_ready,
        output in_ready, out_valid, result, flags_out
    );
endinterface

// File: rtl/pipe_data_path.sv
// Two-stage (EX -> WB) datapath: register file, ALU, status register and WB->EX bypass.
// Flags are {C,Z,N,V,P} in bits [4:0]; one instruction accepted per cycle with backpressure.
module pipe_data_path #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 32,
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             Rst_n,
    pipe_data_path_if.slave  bus
);
    localparam int  AW      = $clog2(NREGS);
    localparam int  SW      = $clog2(WIDTH);
    localparam int  MSB     = WIDTH - 1;
    localparam bit  ZERO_EN = (ZERO_R0 != 32'sd0);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ~(^v);
    endfunction

    logic [WIDTH-1:0] regs_r [NREGS];
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [4:0]       flags_wb_r;
    logic [4:0]       flags_out_r;
    logic [AW-1:0]    rd_wb_r;
    logic             wb_en_wb_r;
    logic             flag_ld_wb_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             retire_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] rs2_val_s;
    logic [WIDTH-1:0] opb_s;
    logic [SW-1:0]    sh_s;
    logic [WIDTH:0]   ext_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] res_out_s;
    logic             carry_s;
    logic             ovf_s;
    logic             wr_s;
    logic             fld_s;
    logic [4:0]       flags_s;

    assign in_ready_s    = !out_valid_r || bus.out_ready;
    assign accept_s      = bus.in_valid && in_ready_s;
    assign retire_s      = out_valid_r && bus.out_ready;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags_out = flags_out_r;

    // Operand fetch; the WB entry never targets r0 when it is hard-wired, so the bypass needs no r0 guard.
    always_comb begin
        opa_s     = '0;
        rs2_val_s = '0;
        if (ZERO_EN && (bus.rs1 == '0)) begin
            opa_s = '0;
        end else if (out_valid_r && wb_en_wb_r && (rd_wb_r == bus.rs1)) begin
            opa_s = result_r;
        end else begin
            opa_s = regs_r[bus.rs1];
        end
        if (ZERO_EN && (bus.rs2 == '0)) begin
            rs2_val_s = '0;
        end else if (out_valid_r && wb_en_wb_r && (rd_wb_r == bus.rs2)) begin
            rs2_val_s = result_r;
        end else begin
            rs2_val_s = regs_r[bus.rs2];
        end
    end

    assign opb_s = bus.use_imm ? bus.imm : rs2_val_s;
    assign sh_s  = opb_s[SW-1:0];

    // ALU and flag generation; the extra ext_s bit carries the carry/borrow or last shifted-out bit.
    always_comb begin
        ext_s     = '0;
        alu_res_s = '0;
        carry_s   = 1'b0;
        ovf_s     = 1'b0;
        wr_s      = 1'b1;
        fld_s     = 1'b1;
        case (bus.opcode)
            OP_ADD: begin
                ext_s     = {1'b0, opa_s} + {1'b0, opb_s};
                alu_res_s = ext_s[WIDTH-1:0];
                carry_s   = ext_s[WIDTH];
                ovf_s     = (opa_s[MSB] == opb_s[MSB]) && (alu_res_s[MSB] != opa_s[MSB]);
            end
            OP_SUB, OP_CMP: begin
                ext_s     = {1'b0, opa_s} - {1'b0, opb_s};
                alu_res_s = ext_s[WIDTH-1:0];
                carry_s   = ext_s[WIDTH];
                ovf_s     = (opa_s[MSB] != opb_s[MSB]) && (alu_res_s[MSB] != opa_s[MSB]);
                wr_s      = (bus.opcode == OP_SUB);
            end
            OP_AND: alu_res_s = opa_s & opb_s;
            OP_OR:  alu_res_s = opa_s | opb_s;
            OP_XOR: alu_res_s = opa_s ^ opb_s;
            OP_NOT: alu_res_s = ~opa_s;
            OP_SHL: begin
                ext_s     = {1'b0, opa_s} << sh_s;
                alu_res_s = ext_s[WIDTH-1:0];
                carry_s   = ext_s[WIDTH];
            end
            OP_SHR: begin
                ext_s     = {opa_s, 1'b0} >> sh_s;
                alu_res_s = ext_s[WIDTH:1];
                carry_s   = ext_s[0];
            end
            OP_SRA: begin
                ext_s     = $signed({opa_s, 1'b0}) >>> sh_s;
                alu_res_s = ext_s[WIDTH:1];
                carry_s   = ext_s[0];
            end
            OP_MOV: alu_res_s = opb_s;
            default: begin
                alu_res_s = '0;
                wr_s      = 1'b0;
                fld_s     = 1'b0;
            end
        endcase
        flags_s   = {carry_s, (alu_res_s == '0), alu_res_s[MSB], ovf_s, even_parity(alu_res_s)};
        res_out_s = (bus.opcode == OP_CMP) ? '0 : alu_res_s;
    end

    // WB stage register and status register; a stall simply holds everything.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_r  <= 1'b0;
            result_r     <= '0;
            flags_wb_r   <= 5'b0;
            flags_out_r  <= 5'b0;
            rd_wb_r      <= '0;
            wb_en_wb_r   <= 1'b0;
            flag_ld_wb_r <= 1'b0;
        end else begin
            if (retire_s && flag_ld_wb_r) begin
                flags_out_r <= flags_wb_r;
            end
            if (accept_s) begin
                out_valid_r  <= 1'b1;
                result_r     <= res_out_s;
                flags_wb_r   <= flags_s;
                rd_wb_r      <= bus.rd;
                wb_en_wb_r   <= bus.wb_en && wr_s && !(ZERO_EN && (bus.rd == '0));
                flag_ld_wb_r <= bus.flag_ld && fld_s;
            end else if (retire_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Architectural register file, written only when the WB entry retires.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (retire_s && wb_en_wb_r) begin
            regs_r[rd_wb_r] <= result_r;
        end
    end
endmodule

// File: tb/tb_pipe_data_path.sv
// Self-checking bench for pipe_data_path: directed scenarios plus random traffic
// compared against an architectural (in-order, instant-commit) integer model.
module tb_pipe_data_path;
    localparam int W = 16;
    localparam longint M = 65536;
    localparam longint H = 32768;

    logic clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_data_path_if #(.WIDTH(16), .NREGS(32)) bus ();
    pipe_data_path #(.WIDTH(16), .NREGS(32), .ZERO_R0(1)) dut (
        .clk(clk), .Rst_n(Rst_n), .bus(bus.slave)
    );

    typedef struct { longint res; logic [4:0] fl; bit fld; } wb_t;
    wb_t        q[$];
    longint     mregs[32];
    logic [4:0] mflags;
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one instruction; flags follow the true value even for CMP.
    task automatic alu_model(input int op, input longint a, input longint b,
                             output longint res, output logic [4:0] fl, output bit wr, output bit ldf);
        longint sa, sb, t, sr;
        int sh;
        bit c, v, z, n, p;
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        sh = int'(b % 16);
        c = 0; v = 0; res = 0; wr = 1; ldf = 1;
        case (op)
            0: begin t = a + b; res = t % M; c = (t >= M); v = (sa + sb > H - 1) || (sa + sb < -H); end
            1, 10: begin t = a - b; res = (t + M) % M; c = (a < b); v = (sa - sb > H - 1) || (sa - sb < -H); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (M - 1) - a;
            6: begin res = (a << sh) % M; c = (sh > 0) && (((a >> (W - sh)) & 1) == 1); end
            7: begin res = a >> sh; c = (sh > 0) && (((a >> (sh - 1)) & 1) == 1); end
            8: begin
                sr = sa >>> sh;
                res = (sr < 0) ? sr + M : sr;
                c = (sh > 0) && (((a >> (sh - 1)) & 1) == 1);
            end
            9: res = b;
            default: begin res = 0; wr = 0; ldf = 0; end
        endcase
        z = (res == 0);
        n = (res >= H);
        p = ($countones(res) % 2) == 0;
        fl = {c, z, n, v, p};
        if (op == 10) begin res = 0; wr = 0; end
    endtask

    // One clock: check outputs at negedge, advance the model, return past the next posedge.
    task automatic step(output bit acc);
        bit exp_rdy, ret, wr, ldf;
        longint a, b, res;
        logic [4:0] fl;
        wb_t e;
        @(negedge clk);
        exp_rdy = (q.size() == 0) || bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("flags_out", 32'(bus.flags_out), 32'(mflags));
        if (q.size() != 0) chk("result", 32'(bus.result), 32'(q[0].res));
        ret = (q.size() != 0) && bus.out_ready;
        acc = bus.in_valid && exp_rdy;
        if (ret) begin
            e = q.pop_front();
            if (e.fld) mflags = e.fl;
        end
        if (acc) begin
            a = mregs[bus.rs1];
            b = bus.use_imm ? longint'(bus.imm) : mregs[bus.rs2];
            alu_model(int'(bus.opcode), a, b, res, fl, wr, ldf);
            e.res = res; e.fl = fl; e.fld = ldf && bus.flag_ld;
            q.push_back(e);
            if (wr && bus.wb_en && bus.rd != 0) mregs[bus.rd] = res;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                         input int imm, input bit ui, input bit we, input bit fl);
        bit acc;
        int budget;
        bus.opcode = 4'(op); bus.rd = 5'(rd); bus.rs1 = 5'(rs1); bus.rs2 = 5'(rs2);
        bus.imm = 16'(imm); bus.use_imm = ui; bus.wb_en = we; bus.flag_ld = fl;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 20) begin
            step(acc);
            budget++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step(acc);
    endtask

    task automatic do_reset();
        bit acc;
        @(posedge clk);
        #1 Rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_flags", 32'(bus.flags_out), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        q.delete();
        foreach (mregs[i]) mregs[i] = 0;
        mflags = 5'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        Rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(acc);
    endtask

    initial begin
        bit acc;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.opcode = 4'd0; bus.rd = 5'd0;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 16'd0; bus.use_imm = 1'b0;
        bus.wb_en = 1'b0; bus.flag_ld = 1'b0;
        do_reset();

        // Back-to-back ADDs exercising the WB->EX bypass.
        issue(0, 1, 0, 0, 16'h7FFF, 1, 1, 0);
        issue(0, 2, 1, 0, 16'h0001, 1, 1, 1);
        drain();
        chk("t2_flags", 32'(bus.flags_out), 32'(5'b00110));
        issue(0, 0, 2, 0, 0, 1, 0, 0);
        drain();

        // SUB into r3 and a write attempt on r0.
        issue(1, 3, 0, 0, 16'h0001, 1, 1, 1);
        issue(1, 0, 0, 0, 16'h0001, 1, 1, 0);
        issue(0, 0, 0, 0, 0, 1, 0, 0);
        drain();
        chk("t3_flags", 32'(bus.flags_out), 32'(5'b10101));

        // Three-cycle stall with an instruction waiting, then release.
        bus.out_ready = 1'b0;
        issue(0, 10, 0, 0, 16'h1111, 1, 1, 1);
        bus.opcode = 4'd0; bus.rd = 5'd11; bus.rs1 = 5'd10; bus.imm = 16'h0002;
        bus.use_imm = 1'b1; bus.wb_en = 1'b1; bus.flag_ld = 1'b0; bus.in_valid = 1'b1;
        repeat (3) step(acc);
        bus.out_ready = 1'b1;
        issue(0, 11, 10, 0, 16'h0002, 1, 1, 0);
        issue(9, 12, 0, 11, 0, 0, 1, 0);
        issue(0, 0, 12, 0, 0, 1, 0, 0);
        drain();

        // Shifts: carry from SHL, sign fill of SRA, no carry on zero shift.
        issue(0, 5, 0, 0, 16'h8001, 1, 1, 0);
        issue(6, 6, 5, 0, 1, 1, 1, 1);
        drain();
        chk("t5_shl_flags", 32'(bus.flags_out), 32'(5'b10000));
        issue(0, 7, 0, 0, 16'h8000, 1, 1, 0);
        issue(8, 13, 7, 0, 15, 1, 1, 0);
        issue(7, 14, 5, 0, 0, 1, 1, 1);
        drain();
        chk("t5_shr_flags", 32'(bus.flags_out), 32'(5'b00101));

        // CMP leaves rd alone; opcode 12 neither writes nor loads flags.
        issue(0, 8, 0, 0, 5, 1, 1, 0);
        issue(0, 9, 0, 0, 16'h00AA, 1, 1, 0);
        issue(10, 9, 8, 0, 5, 1, 1, 1);
        issue(12, 9, 8, 0, 7, 1, 1, 1);
        drain();
        chk("t6_flags", 32'(bus.flags_out), 32'(5'b01001));
        issue(0, 0, 9, 0, 0, 1, 0, 0);
        drain();

        // Random traffic with random backpressure and a small register window for hazards.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.opcode    = 4'($urandom_range(0, 15));
            bus.rd        = 5'($urandom_range(0, 7));
            bus.rs1       = 5'($urandom_range(0, 7));
            bus.rs2       = 5'($urandom_range(0, 7));
            bus.imm       = 16'($urandom);
            bus.use_imm   = 1'($urandom_range(0, 1));
            bus.wb_en     = ($urandom_range(0, 9) < 7);
            bus.flag_ld   = 1'($urandom_range(0, 1));
            step(acc);
        end
        drain();

        // Reset while a write sits stalled in WB: the write must be lost.
        bus.out_ready = 1'b0;
        issue(0, 15, 0, 0, 16'h1234, 1, 1, 1);
        step(acc);
        do_reset();
        issue(0, 0, 15, 0, 0, 1, 0, 0);
        issue(0, 0, 1, 0, 0, 1, 0, 0);
        drain();
        chk("post_rst_r15", 32'(bus.result), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
